// File: rtl/full_adder_reg_if.sv
// Operand/result bundle for full_adder_reg. Define FA_OVERFLOW_EN to add the ov signal.
// Handshake: valid-only, no ready. The master presents a0/a1/c0 with in_valid=1 for one
// edge and the slave returns s/c1 (and ov) with out_valid=1 one cycle later. The slave
// never stalls, so a valid input is accepted on every edge where in_valid=1.
interface full_adder_reg_if #(
   parameter int WIDTH = 1
);
   logic             in_valid;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] a1;
   logic             c0;
   logic [WIDTH-1:0] s;
   logic             c1;
   logic             out_valid;
`ifdef FA_OVERFLOW_EN
   logic             ov;

   modport master (output in_valid, a0, a1, c0, input s, c1, out_valid, ov);
   modport slave  (input in_valid, a0, a1, c0, output s, c1, out_valid, ov);
`else
   modport master (output in_valid, a0, a1, c0, input s, c1, out_valid);
   modport slave  (input in_valid, a0, a1, c0, output s, c1, out_valid);
`endif
endinterface

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {c1,s} = a0 + a1 + c0, captured one cycle after in_valid.
// Define FA_OVERFLOW_EN to add a registered two's-complement overflow flag (ov).
module full_adder_reg #(
   parameter int WIDTH = 1
) (
   input  logic            clk,
   input  logic            reset,
   full_adder_reg_if.slave bus
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] s_q;
   logic             c1_q;
   logic             valid_q;

   // carry[i] is the carry into bit i; carry[WIDTH] is the adder carry-out.
   always_comb begin
      carry    = '0;
      sum_d    = '0;
      carry[0] = bus.c0;
      for (int i = 0; i < WIDTH; i++) begin
         sum_d[i]     = bus.a0[i] ^ bus.a1[i] ^ carry[i];
         carry[i + 1] = (bus.a0[i] & bus.a1[i]) | (bus.a0[i] & carry[i]) |
                        (bus.a1[i] & carry[i]);
      end
   end

   // Result registers only load on in_valid, so operands that are X while idle cannot reach them.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_q     <= '0;
         c1_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            s_q  <= sum_d;
            c1_q <= carry[WIDTH];
         end
      end
   end

   assign bus.s         = s_q;
   assign bus.c1        = c1_q;
   assign bus.out_valid = valid_q;

`ifdef FA_OVERFLOW_EN
   logic ov_d;
   logic ov_q;

   assign ov_d = carry[WIDTH - 1] ^ carry[WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         ov_q <= 1'b0;
      end else if (bus.in_valid) begin
         ov_q <= ov_d;
      end
   end

   assign bus.ov = ov_q;
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed bench for full_adder_reg at WIDTH=1 and WIDTH=8 (FA_OVERFLOW_EN adds ov checks).
module tb_full_adder_reg;

   logic clk;
   logic reset;

   full_adder_reg_if #(.WIDTH(1)) bus1 ();
   full_adder_reg_if #(.WIDTH(8)) bus8 ();

   full_adder_reg #(.WIDTH(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
   full_adder_reg #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- vector tables ----------------
   typedef struct {
      logic [2:0] cba;     // {c0,a1,a0}
      logic       exp_c1;
      logic       exp_s;
      logic       exp_ov;
   } vec1_t;

   typedef struct {
      logic [7:0] a0;
      logic [7:0] a1;
      logic       c0;
      logic [7:0] exp_s;
      logic       exp_c1;
      logic       exp_ov;
   } vec8_t;

   vec1_t v1[8];
   vec8_t v8[7];

   // Scoreboard for the 8-bit lane: {ov, c1, s} pushed at drive time, popped one edge later.
   logic [9:0] exp_q[$];

   int tests_run = 0;
   int tests_failed = 0;

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive8(input logic [7:0] a0, input logic [7:0] a1, input logic c0,
                         input logic [7:0] es, input logic ec1, input logic eov);
      bus8.in_valid = 1'b1;
      bus8.a0       = a0;
      bus8.a1       = a1;
      bus8.c0       = c0;
      exp_q.push_back({eov, ec1, es});
   endtask

   task automatic score8(input string name);
      logic [9:0] e;
      if (exp_q.size() == 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         check({name, ".s"}, 32'(bus8.s), 32'(e[7:0]));
         check({name, ".c1"}, 32'(bus8.c1), 32'(e[8]));
         check({name, ".out_valid"}, 32'(bus8.out_valid), 32'd1);
`ifdef FA_OVERFLOW_EN
         check({name, ".ov"}, 32'(bus8.ov), 32'(e[9]));
`endif
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      v1[0] = '{3'b000, 1'b0, 1'b0, 1'b0};
      v1[1] = '{3'b001, 1'b0, 1'b1, 1'b0};
      v1[2] = '{3'b010, 1'b0, 1'b1, 1'b0};
      v1[3] = '{3'b011, 1'b1, 1'b0, 1'b1};
      v1[4] = '{3'b100, 1'b0, 1'b1, 1'b1};
      v1[5] = '{3'b101, 1'b1, 1'b0, 1'b0};
      v1[6] = '{3'b110, 1'b1, 1'b0, 1'b0};
      v1[7] = '{3'b111, 1'b1, 1'b1, 1'b0};

      v8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      v8[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
      v8[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      v8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      v8[4] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
      v8[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      v8[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

      reset = 1'b1;
      bus1.in_valid = 1'b0; bus1.a0 = '0; bus1.a1 = '0; bus1.c0 = 1'b0;
      bus8.in_valid = 1'b0; bus8.a0 = '0; bus8.a1 = '0; bus8.c0 = 1'b0;
      step();
      step();
      check("rst.w1.s", 32'(bus1.s), 32'd0);
      check("rst.w1.c1", 32'(bus1.c1), 32'd0);
      check("rst.w1.out_valid", 32'(bus1.out_valid), 32'd0);
      check("rst.w8.s", 32'(bus8.s), 32'd0);
      check("rst.w8.out_valid", 32'(bus8.out_valid), 32'd0);
`ifdef FA_OVERFLOW_EN
      check("rst.w8.ov", 32'(bus8.ov), 32'd0);
`endif
      reset = 1'b0;

      // WIDTH=1 truth-table sweep, one vector per cycle.
      for (int i = 0; i < 8; i++) begin
         bus1.in_valid = 1'b1;
         {bus1.c0, bus1.a1, bus1.a0} = v1[i].cba;
         step();
         check($sformatf("w1[%0d].s", i), 32'(bus1.s), 32'(v1[i].exp_s));
         check($sformatf("w1[%0d].c1", i), 32'(bus1.c1), 32'(v1[i].exp_c1));
         check($sformatf("w1[%0d].out_valid", i), 32'(bus1.out_valid), 32'd1);
`ifdef FA_OVERFLOW_EN
         check($sformatf("w1[%0d].ov", i), 32'(bus1.ov), 32'(v1[i].exp_ov));
`endif
      end
      bus1.in_valid = 1'b0;
      {bus1.c0, bus1.a1, bus1.a0} = 3'b000;
      step();
      check("w1.idle.out_valid", 32'(bus1.out_valid), 32'd0);
      check("w1.idle.s_hold", 32'(bus1.s), 32'd1);
      check("w1.idle.c1_hold", 32'(bus1.c1), 32'd1);

      // WIDTH=8 back-to-back vectors.
      for (int i = 0; i < 7; i++) begin
         drive8(v8[i].a0, v8[i].a1, v8[i].c0, v8[i].exp_s, v8[i].exp_c1, v8[i].exp_ov);
         step();
         score8($sformatf("w8[%0d]", i));
      end

      // Valid gap: 2+3 then three idle cycles with wandering operands.
      drive8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);
      step();
      score8("gap.load");
      for (int k = 0; k < 3; k++) begin
         bus8.in_valid = 1'b0;
         bus8.a0 = (k == 1) ? 8'hxx : 8'($urandom_range(0, 255));
         bus8.a1 = 8'($urandom_range(128, 255));
         bus8.c0 = 1'b1;
         step();
         check($sformatf("gap[%0d].s", k), 32'(bus8.s), 32'h05);
         check($sformatf("gap[%0d].c1", k), 32'(bus8.c1), 32'd0);
         check($sformatf("gap[%0d].out_valid", k), 32'(bus8.out_valid), 32'd0);
      end

      // Reset overrides a valid 1+1 on the same edge.
      bus8.in_valid = 1'b1; bus8.a0 = 8'h01; bus8.a1 = 8'h01; bus8.c0 = 1'b0;
      reset = 1'b1;
      step();
      check("rst_mid.s", 32'(bus8.s), 32'd0);
      check("rst_mid.c1", 32'(bus8.c1), 32'd0);
      check("rst_mid.out_valid", 32'(bus8.out_valid), 32'd0);
      reset = 1'b0;
      drive8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
      step();
      score8("post_rst");
      bus8.in_valid = 1'b0;
      step();
      check("post_rst.idle.out_valid", 32'(bus8.out_valid), 32'd0);
      check("post_rst.idle.s_hold", 32'(bus8.s), 32'h02);
      check("scoreboard.drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
